// File: rtl/debouncer_multi_pkg.sv
// Shared types and constants for the multi-channel debouncer.
// Channel FSM encoding and the nominal tick rate.
package debouncer_multi_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } db_state_t;

  localparam int TICK_HZ = 1000;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF sync, settle FSM, tick counter.
// Optional hold counter under DEBOUNCE_LONGPRESS_EN.
module debounce_channel
  import debouncer_multi_pkg::*;
#(
  parameter int   DEBOUNCE_MS = 15,
  parameter logic RESET_VAL   = 1'b0,
  parameter int   LONG_MS     = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse1kHz,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  if (DEBOUNCE_MS < 1 || LONG_MS < 1) begin : g_param_err
    $error("debounce_channel: DEBOUNCE_MS and LONG_MS must be >= 1");
  end

  logic          meta;
  logic          s;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser preloaded with the reset level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      s    <= RESET_VAL;
    end else begin
      meta <= in;
      s    <= meta;
    end
  end

  // Settle FSM: any bounce back to out restarts the timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_STABLE;
      cnt   <= '0;
      out   <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_STABLE: begin
          cnt <= '0;
          if (s != out) state <= ST_CHANGING;
        end
        ST_CHANGING: begin
          if (s == out) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (pulse1kHz) begin
            if (cnt == CNT_LAST) begin
              out   <= s;
              cnt   <= '0;
              state <= ST_STABLE;
              rise  <= s;
              fall  <= ~s;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int HW = $clog2(LONG_MS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS);

  logic [HW-1:0] hold;

  // Hold timer: saturates so a press yields a single pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!out) begin
        hold <= '0;
      end else if (pulse1kHz && hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
        if (hold == HOLD_MAX - 1'b1) long_press <= 1'b1;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// WIDTH independent debounce channels sharing one 1 kHz tick.
// Long-press pulses only with DEBOUNCE_LONGPRESS_EN defined.
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               DEBOUNCE_MS = 15,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               LONG_MS     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse1kHz,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] long_press
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .RESET_VAL  (RESET_VAL[i]),
      .LONG_MS    (LONG_MS)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .pulse1kHz (pulse1kHz),
      .in        (in[i]),
      .out       (out[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: directed scenarios plus random bouncing,
// checked every clock against a tick-timestamp reference model.
module tb_debouncer_multi;

  localparam int W    = 4;
  localparam int DB   = 15;
  localparam int LONG = 1000;
  localparam int TP   = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pulse = 1'b0;
  logic [W-1:0] in_v = '0;
  logic [W-1:0] out_v, rise_v, fall_v, lp_v;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_rise0 = 0;

  debouncer_multi #(
    .WIDTH(W), .DEBOUNCE_MS(DB), .RESET_VAL('0), .LONG_MS(LONG)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .pulse1kHz (pulse),
    .in        (in_v),
    .out       (out_v),
    .rise      (rise_v),
    .fall      (fall_v),
    .long_press(lp_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  // Reference: s is in delayed by two clocks; out flips once s has
  // disagreed with out through DB ticks counted after the clock on
  // which the disagreement was first seen.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall, m_lp, o_prev;
  int unsigned  ticks = 0;
  int unsigned  chg_base [W];
  int unsigned  hold_base[W];
  bit           chg      [W];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_out = '0;
      m_rise = '0; m_fall = '0; m_lp = '0;
      for (int i = 0; i < W; i++) chg[i] = 0;
    end else begin
      o_prev = m_out;
      if (pulse) ticks++;
      m_rise = '0; m_fall = '0; m_lp = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == o_prev[i]) begin
          chg[i] = 0;
        end else if (!chg[i]) begin
          chg[i] = 1;
          chg_base[i] = ticks;
        end else if (pulse && ticks - chg_base[i] == DB) begin
          m_out[i]  = m_s2[i];
          m_rise[i] = m_s2[i];
          m_fall[i] = ~m_s2[i];
          chg[i]    = 0;
        end
`ifdef DEBOUNCE_LONGPRESS_EN
        if (o_prev[i] && pulse && ticks - hold_base[i] == LONG)
          m_lp[i] = 1'b1;
`endif
        if (!o_prev[i] && m_out[i]) hold_base[i] = ticks;
      end
      m_s2 = m_s1;
      m_s1 = in_v;
    end
    #1;
    chk("out",  32'(out_v),  32'(m_out));
    chk("rise", 32'(rise_v), 32'(m_rise));
    chk("fall", 32'(fall_v), 32'(m_fall));
    chk("long", 32'(lp_v),   32'(m_lp));
    if (rise_v[0]) n_rise0++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      pulse = (cyc % TP == 0);
    end
  endtask

  task automatic tick(input int n);
    step(n * TP);
  endtask

  initial begin
    int idx;
    // 1: reset held with all inputs high, then released
    in_v = 4'hF;
    step(10);
    rst_n = 1'b1;
    tick(20);
    chk("t1_out", 32'(out_v), 32'hF);
    // settle low
    in_v = 4'h0;
    tick(20);
    // 2: in[0] bounces every 3 ticks, then holds high
    n_rise0 = 0;
    for (int k = 0; k < 10; k++) begin
      in_v[0] = ~in_v[0];
      tick(3);
    end
    in_v[0] = 1'b1;
    tick(20);
    chk("t2_rise_cnt", 32'(n_rise0), 32'd1);
    chk("t2_out0", 32'(out_v[0]), 32'd1);
    // 3: staggered rises on channels 1 and 2
    in_v[1] = 1'b1;
    tick(5);
    in_v[2] = 1'b1;
    tick(20);
    chk("t3_out", 32'(out_v), 32'h7);
    // 4: channel 3 up, then down
    in_v[3] = 1'b1;
    tick(20);
    in_v[3] = 1'b0;
    tick(20);
    chk("t4_out3", 32'(out_v[3]), 32'd0);
    // 5: reset in the middle of a count
    in_v = 4'h0;
    tick(20);
    in_v[0] = 1'b1;
    tick(10);
    rst_n = 1'b0;
    step(3);
    chk("t5_rst_out", 32'(out_v), 32'h0);
    rst_n = 1'b1;
    tick(10);
    chk("t5_early", 32'(out_v[0]), 32'd0);
    tick(10);
    chk("t5_late", 32'(out_v[0]), 32'd1);
    // 6: long hold on channel 2
    in_v = 4'h0;
    tick(20);
    in_v[2] = 1'b1;
`ifdef DEBOUNCE_LONGPRESS_EN
    tick(2500);
`else
    tick(40);
`endif
    in_v = 4'h0;
    tick(20);
    // random bouncing with occasional quiet stretches
    for (int k = 0; k < 6000; k++) begin
      step(1);
      if ($urandom_range(0, 29) == 0) begin
        idx = $urandom_range(0, W - 1);
        in_v[idx] = ~in_v[idx];
      end
      if (k % 700 == 699) tick(20);
      if (k == 3000) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
    end
    tick(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
